gumnut_data_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the 8-bit Wishbone-classic data memory bus.
- Master 0 is the gumnut data bus (data_cyc_o/stb_o/we_o/adr_o/dat_o, data_ack_i/dat_i). Master 1 is a secondary requester, such as a debug loader or DMA engine.
- Grants the single data memory to one master at a time using round-robin priority.
- The grant is held for the full length of the master's cyc, which allows locked multi-beat sequences.

---
 rtl/gumnut_data_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_gumnut_data_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gumnut_data_arbiter.sv
// gumnut_data_arbiter: round-robin arbiter that lets two Wishbone-classic
// masters share one 8-bit data memory slave. A grant is held for the full
// length of the master's cyc, so locked multi-beat sequences are not split.
// Optional build macro ARB_TIMEOUT_EN adds a stalled-strobe watchdog with
// per-master error pulses (m0_err_o/m1_err_o) and a re-request lockout.
module gumnut_data_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
`ifdef ARB_TIMEOUT_EN
    output logic              m0_err_o,
    output logic              m1_err_o,
`endif
    output logic [1:0]        grant_o
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t r_state, w_state_nxt;
    logic   r_ptr, w_ptr_nxt;       // 0: m0 wins a tie, 1: m1 wins a tie
    logic   w_req0, w_req1;         // requests eligible for arbitration
    logic   w_timeout;              // granted master has stalled too long

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] STALL_LIM = 8'(TIMEOUT - 1);

    logic [7:0] r_stall;
    logic       r_blk0, r_blk1;     // master locked out after its timeout
    logic       r_err0, r_err1;
    logic       w_stalled;

    assign w_stalled = ((r_state == GNT0 && m0_stb_i) ||
                        (r_state == GNT1 && m1_stb_i)) && !s_ack_i;
    assign w_timeout = w_stalled && (r_stall == STALL_LIM);
    assign w_req0    = m0_cyc_i && !r_blk0;
    assign w_req1    = m1_cyc_i && !r_blk1;
    assign m0_err_o  = r_err0;
    assign m1_err_o  = r_err1;

    // Stall counter: restarts on every new grant and every slave ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_stall <= '0;
        else if (r_state == IDLE || s_ack_i || w_timeout)
            r_stall <= '0;
        else if (w_stalled)
            r_stall <= r_stall + 8'd1;
    end

    // Lockout and one-cycle error pulse for the master that timed out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_blk0 <= 1'b0;
            r_blk1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            r_err0 <= w_timeout && (r_state == GNT0);
            r_err1 <= w_timeout && (r_state == GNT1);
            if (w_timeout && r_state == GNT0)
                r_blk0 <= 1'b1;
            else if (!m0_cyc_i)
                r_blk0 <= 1'b0;
            if (w_timeout && r_state == GNT1)
                r_blk1 <= 1'b1;
            else if (!m1_cyc_i)
                r_blk1 <= 1'b0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_req0    = m0_cyc_i;
    assign w_req1    = m1_cyc_i;
`endif

    // State and round-robin pointer registers; reset favours m0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state: arbitrate only from IDLE, release points to the other master.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_req0 && (!w_req1 || !r_ptr))
                    w_state_nxt = GNT0;
                else if (w_req1)
                    w_state_nxt = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i || w_timeout) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = 1'b1;
                end
            end
            GNT1: begin
                if (!m1_cyc_i || w_timeout) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign grant_o = r_state;

    // Combinational bus routing; everything idles at zero when not granted.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        case (r_state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gumnut_data_arbiter.sv
// Testbench for gumnut_data_arbiter: table of per-cycle directed vectors plus
// hand-written sequences for mid-transfer reset and the optional timeout.
module tb_gumnut_data_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       m0_cyc_i, m0_stb_i, m0_we_i;
    logic [7:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic       m0_ack_o;
    logic       m1_cyc_i, m1_stb_i, m1_we_i;
    logic [7:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic       m1_ack_o;
    logic       s_cyc_o, s_stb_o, s_we_o;
    logic [7:0] s_adr_o, s_dat_o, s_dat_i;
    logic       s_ack_i;
    logic [1:0] grant_o;
`ifdef ARB_TIMEOUT_EN
    logic       m0_err_o, m1_err_o;
`endif

    int errors = 0;
    int checks = 0;

    gumnut_data_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i),
`ifdef ARB_TIMEOUT_EN
        .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
`endif
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rs;
        logic        c0, s0, w0;
        logic [7:0]  a0, d0;
        logic        c1, s1, w1;
        logic [7:0]  a1, d1;
        logic [7:0]  sd;
        logic        sa;
        logic [1:0]  g;
        logic [18:0] sbus;   // {cyc, stb, we, adr, dat}
        logic [8:0]  m0r;    // {ack, dat}
        logic [8:0]  m1r;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [18:0] B(logic c, logic s, logic w, logic [7:0] a, logic [7:0] d);
        return {c, s, w, a, d};
    endfunction

    function automatic logic [8:0] R(logic k, logic [7:0] d);
        return {k, d};
    endfunction

    function automatic vec_t mk(logic rs,
                                logic c0, logic s0, logic w0, logic [7:0] a0, logic [7:0] d0,
                                logic c1, logic s1, logic w1, logic [7:0] a1, logic [7:0] d1,
                                logic [7:0] sd, logic sa, logic [1:0] g,
                                logic [18:0] sbus, logic [8:0] m0r, logic [8:0] m1r);
        vec_t v;
        v.rs = rs; v.c0 = c0; v.s0 = s0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.c1 = c1; v.s1 = s1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.sd = sd; v.sa = sa; v.g = g; v.sbus = sbus; v.m0r = m0r; v.m1r = m1r;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_dat_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_dat_i = 0;
        s_dat_i = 0; s_ack_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic run_vec(vec_t v, int idx);
        if (v.rs) do_reset();
        m0_cyc_i = v.c0; m0_stb_i = v.s0; m0_we_i = v.w0; m0_adr_i = v.a0; m0_dat_i = v.d0;
        m1_cyc_i = v.c1; m1_stb_i = v.s1; m1_we_i = v.w1; m1_adr_i = v.a1; m1_dat_i = v.d1;
        s_dat_i = v.sd; s_ack_i = v.sa;
        @(posedge clk_i); #1;
        chk($sformatf("v%0d grant", idx), 32'(grant_o), 32'(v.g));
        chk($sformatf("v%0d slave", idx), 32'({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o}), 32'(v.sbus));
        chk($sformatf("v%0d m0", idx), 32'({m0_ack_o, m0_dat_o}), 32'(v.m0r));
        chk($sformatf("v%0d m1", idx), 32'({m1_ack_o, m1_dat_o}), 32'(v.m1r));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // m0 single read of 0x10, ack with 0xA5 on 2nd granted cycle
        vecs.push_back(mk(1, 1,1,0,8'h10,0, 0,0,0,0,0, 8'h00,0, 2'b01, B(1,1,0,8'h10,0), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 1,1,0,8'h10,0, 0,0,0,0,0, 8'hA5,1, 2'b01, B(1,1,0,8'h10,0), R(1,8'hA5), R(0,0)));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0, 8'h00,0, 2'b00, B(0,0,0,0,0), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0, 8'h00,0, 2'b00, B(0,0,0,0,0), R(0,0), R(0,0)));
        // simultaneous request after reset: m0 first, one IDLE, then m1
        vecs.push_back(mk(1, 1,1,0,8'h30,0, 1,1,0,8'h40,0, 8'h5A,1, 2'b01, B(1,1,0,8'h30,0), R(1,8'h5A), R(0,0)));
        vecs.push_back(mk(0, 0,0,0,0,0,     1,1,0,8'h40,0, 8'h00,0, 2'b00, B(0,0,0,0,0), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 0,0,0,0,0,     1,1,0,8'h40,0, 8'hC3,1, 2'b10, B(1,1,0,8'h40,0), R(0,0), R(1,8'hC3)));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0,     8'h00,0, 2'b00, B(0,0,0,0,0), R(0,0), R(0,0)));
        // m1 locked three-write burst while m0 waits; ack during stb gap still forwarded
        vecs.push_back(mk(0, 0,0,0,0,0,     1,1,1,8'h20,8'h11, 8'h00,0, 2'b10, B(1,1,1,8'h20,8'h11), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 1,1,0,8'h50,0, 1,1,1,8'h20,8'h11, 8'h00,1, 2'b10, B(1,1,1,8'h20,8'h11), R(0,0), R(1,0)));
        vecs.push_back(mk(0, 1,1,0,8'h50,0, 1,1,1,8'h21,8'h22, 8'h00,1, 2'b10, B(1,1,1,8'h21,8'h22), R(0,0), R(1,0)));
        vecs.push_back(mk(0, 1,1,0,8'h50,0, 1,0,1,8'h21,8'h22, 8'h77,1, 2'b10, B(1,0,1,8'h21,8'h22), R(0,0), R(1,8'h77)));
        vecs.push_back(mk(0, 1,1,0,8'h50,0, 1,1,1,8'h22,8'h33, 8'h00,1, 2'b10, B(1,1,1,8'h22,8'h33), R(0,0), R(1,0)));
        vecs.push_back(mk(0, 1,1,0,8'h50,0, 0,0,0,0,0,     8'h00,0, 2'b00, B(0,0,0,0,0), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 1,1,0,8'h50,0, 0,0,0,0,0,     8'h00,0, 2'b01, B(1,1,0,8'h50,0), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0,     8'h00,0, 2'b00, B(0,0,0,0,0), R(0,0), R(0,0)));
        // m0 releases and re-requests at once while m1 waits: m1 goes next
        vecs.push_back(mk(1, 1,1,0,8'h60,0, 0,0,0,0,0,     8'h00,0, 2'b01, B(1,1,0,8'h60,0), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 1,1,0,8'h60,0, 1,1,0,8'h70,0, 8'h00,0, 2'b01, B(1,1,0,8'h60,0), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 0,0,0,0,0,     1,1,0,8'h70,0, 8'h00,0, 2'b00, B(0,0,0,0,0), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 1,1,0,8'h60,0, 1,1,0,8'h70,0, 8'h00,0, 2'b10, B(1,1,0,8'h70,0), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 1,1,0,8'h60,0, 1,1,0,8'h70,0, 8'h00,0, 2'b10, B(1,1,0,8'h70,0), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 1,1,0,8'h60,0, 0,0,0,0,0,     8'h00,0, 2'b00, B(0,0,0,0,0), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 1,1,0,8'h60,0, 0,0,0,0,0,     8'h00,0, 2'b01, B(1,1,0,8'h60,0), R(0,0), R(0,0)));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0,     8'h00,0, 2'b00, B(0,0,0,0,0), R(0,0), R(0,0)));

        // Reset state, with requests and a slave ack present during reset
        idle_inputs();
        rst_i = 1'b1;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1; s_dat_i = 8'hFF;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("reset grant", 32'(grant_o), 32'h0);
        chk("reset slave", 32'({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o}), 32'h0);
        chk("reset m0/m1", 32'({m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o}), 32'h0);
`ifdef ARB_TIMEOUT_EN
        chk("reset err", 32'({m0_err_o, m1_err_o}), 32'h0);
`endif
        idle_inputs();
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset during an unacknowledged m1 write
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 8'h90; m1_dat_i = 8'h44;
        @(posedge clk_i); #1;
        chk("mid-reset pre grant", 32'(grant_o), 32'h2);
        chk("mid-reset pre s_cyc", 32'(s_cyc_o), 32'h1);
        #2 rst_i = 1'b1;
        #1;
        chk("mid-reset s_cyc/stb", 32'({s_cyc_o, s_stb_o}), 32'h0);
        chk("mid-reset grant", 32'(grant_o), 32'h0);
        #1 rst_i = 1'b0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 8'hA0;
        @(posedge clk_i); #1;
        chk("post-reset tie grant", 32'(grant_o), 32'h1);
        chk("post-reset tie adr", 32'(s_adr_o), 32'hA0);
        idle_inputs();
        @(posedge clk_i); #1;
        chk("post-reset idle", 32'(grant_o), 32'h0);

`ifdef ARB_TIMEOUT_EN
        // Slave never acks m0: error after 16 stalled cycles, m1 takes over
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 8'h80;
        m1_cyc_i = 1; m1_stb_i = 0;
        @(posedge clk_i); #1;
        chk("to grant", 32'({grant_o, m0_err_o, m1_err_o}), 32'({2'b01, 2'b00}));
        for (int i = 1; i < 16; i++) begin
            @(posedge clk_i); #1;
            chk($sformatf("to stall %0d", i), 32'({grant_o, m0_err_o}), 32'({2'b01, 1'b0}));
        end
        @(posedge clk_i); #1;
        chk("to err pulse", 32'({grant_o, m0_err_o, m1_err_o}), 32'({2'b00, 2'b10}));
        @(posedge clk_i); #1;
        chk("to m1 granted", 32'({grant_o, m0_err_o}), 32'({2'b10, 1'b0}));
        m1_cyc_i = 0;
        @(posedge clk_i); #1;
        chk("to m1 release", 32'(grant_o), 32'h0);
        @(posedge clk_i); #1;
        chk("to m0 blocked", 32'(grant_o), 32'h0);
        m0_cyc_i = 0; m0_stb_i = 0;
        @(posedge clk_i); #1;
        m0_cyc_i = 1; m0_stb_i = 1;
        @(posedge clk_i); #1;
        chk("to m0 regrant", 32'(grant_o), 32'h1);
        idle_inputs();
        @(posedge clk_i); #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
